// File: rtl/iot_pkg.sv
// Shared definitions for the IoT byte serializer: record geometry, FIFO sizing
// and the serializer FSM state encoding.
package iot_pkg;

  localparam int REC_W         = 128;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_REC = 16;
  localparam int FIFO_DEPTH    = 4;
  localparam int REC_PER_ROUND = 8;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BCNT_W = $clog2(BYTES_PER_REC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/iot_rec_fifo.sv
// Four-entry record FIFO. A push while full is dropped and latches the sticky
// ovf flag; full is judged on the registered count, before any same-cycle pop.
module iot_rec_fifo
  import iot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REC_W-1:0] push_data,
  input  logic             pop,
  output logic [REC_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [REC_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (push && full) ovf_d = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/iot_byte_serializer.sv
// Serializes buffered 128-bit records into 16 MSB-first bytes with a gap after
// each record. Define IOT_SER_ROUND_EN to enable rec_cnt/round_done tracking.
module iot_byte_serializer
  import iot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [REC_W-1:0]  wr_data,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  input  logic              busy,
  output logic              in_en,
  output logic [BYTE_W-1:0] iot_in,
  output logic [2:0]        rec_cnt,
  output logic              round_done
);

  state_e            state_q, state_d;
  logic [REC_W-1:0]  sr_q, sr_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              in_en_q, in_en_d;
  logic [BYTE_W-1:0] iot_in_q, iot_in_d;
  logic              fifo_pop;
  logic [REC_W-1:0]  fifo_head;

  iot_rec_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf)
  );

  // Handshake: in_en marks iot_in valid for one cycle; busy only holds off the
  // start of a record, once a record starts all 16 bytes go out back-to-back.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    byte_cnt_d = byte_cnt_q;
    fifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !busy) begin
          fifo_pop   = 1'b1;
          sr_d       = fifo_head;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        sr_d       = sr_q << BYTE_W;
        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        if (byte_cnt_q == BCNT_W'(BYTES_PER_REC - 1)) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_en_d  = (state_q == S_SEND);
    iot_in_d = in_en_d ? sr_q[REC_W-1 -: BYTE_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      in_en_q    <= 1'b0;
      iot_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      byte_cnt_q <= byte_cnt_d;
      in_en_q    <= in_en_d;
      iot_in_q   <= iot_in_d;
    end
  end

  assign in_en  = in_en_q;
  assign iot_in = iot_in_q;

`ifdef IOT_SER_ROUND_EN
  logic [2:0] rec_cnt_q, rec_cnt_d;
  logic       round_done_q, round_done_d;
  logic       send_done;

  always_comb begin
    send_done    = (state_q == S_SEND) && (byte_cnt_q == BCNT_W'(BYTES_PER_REC - 1));
    rec_cnt_d    = rec_cnt_q;
    round_done_d = 1'b0;
    if (send_done) begin
      rec_cnt_d    = rec_cnt_q + 3'd1;
      round_done_d = (rec_cnt_q == 3'(REC_PER_ROUND - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_cnt_q    <= '0;
      round_done_q <= 1'b0;
    end else begin
      rec_cnt_q    <= rec_cnt_d;
      round_done_q <= round_done_d;
    end
  end

  assign rec_cnt    = rec_cnt_q;
  assign round_done = round_done_q;
`else
  assign rec_cnt    = '0;
  assign round_done = 1'b0;
`endif

endmodule
